// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the EX-stage multiply/divide sequencer:
// M-extension encodings, sequencer FSM states and operand-sign helpers.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [6:0] FUNCT7_M = 7'b0000001;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } m_funct3_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_CALC = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } mdu_state_e;

   // MUL is treated as unsigned: its low word does not depend on operand signs.
   function automatic logic op_signed_a(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic op_signed_b(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Issue/result bundle between the EX-stage decode (master) and the sequencer (slave).
interface mdu_sequencer_if #(parameter int XLEN = riscv_pkg::XLEN);

   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            flush;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, op_a, op_b, flush,
      input  stall, busy, done, result
   );

   modport slave (
      input  start, funct3, op_a, op_b, flush,
      output stall, busy, done, result
   );

endinterface

// File: rtl/mdu_addsub.sv
// Shared adder/subtractor; o_cout=1 on subtraction means no borrow (i_a >= i_b).
module mdu_addsub #(
   parameter int W = 33
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_sub,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);

   logic [W-1:0] w_b;

   assign w_b = i_sub ? ~i_b : i_b;
   assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{W{1'b0}}, i_sub};

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M sequencer: bit-serial shift-add multiply and restoring divide,
// both driven through one shared adder, stalling the pipeline until the result lands.
module mdu_sequencer
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input logic           clk,
   input logic           rst_n,
   mdu_sequencer_if.slave bus
);

   localparam int CW = $clog2(XLEN);
   localparam int AW = XLEN + 1;

   mdu_state_e      r_state;
   m_funct3_e       r_f3;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;
   logic [XLEN-1:0] r_m;
   logic [2*XLEN-1:0] r_acc;
   logic            r_sa;
   logic            r_sb;
   logic            r_busy;
   logic            r_done;
   logic [XLEN-1:0] r_result;

   logic            w_is_div;
   logic [XLEN-1:0] w_mag_a;
   logic [XLEN-1:0] w_mag_b;
   logic [AW-1:0]   w_add_a;
   logic [AW-1:0]   w_add_b;
   logic            w_add_sub;
   logic [AW-1:0]   w_sum;
   logic            w_cout;
   logic [XLEN-1:0] w_fix;

   assign w_is_div = r_f3[2];
   assign w_mag_a  = r_sa ? -r_a : r_a;
   assign w_mag_b  = r_sb ? -r_b : r_b;

   mdu_addsub #(.W(AW)) u_addsub (
      .i_a    (w_add_a),
      .i_b    (w_add_b),
      .i_sub  (w_add_sub),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // Adder operand steering. In FIX the high product word is negated as
   // ~hi + (lo == 0), which is the upper half of the full 2*XLEN negation.
   always_comb begin
      w_add_a   = {AW{1'b0}};
      w_add_b   = {AW{1'b0}};
      w_add_sub = 1'b0;
      if (r_state == S_FIX) begin
         if (!w_is_div) begin
            w_add_a = {1'b0, ~r_acc[2*XLEN-1:XLEN]};
            w_add_b = {{XLEN{1'b0}}, (r_acc[XLEN-1:0] == {XLEN{1'b0}})};
         end else if (r_f3[1]) begin
            w_add_b   = {1'b0, r_acc[2*XLEN-1:XLEN]};
            w_add_sub = 1'b1;
         end else begin
            w_add_b   = {1'b0, r_acc[XLEN-1:0]};
            w_add_sub = 1'b1;
         end
      end else if (w_is_div) begin
         w_add_a   = r_acc[2*XLEN-1:XLEN-1];
         w_add_b   = {1'b0, r_m};
         w_add_sub = 1'b1;
      end else begin
         w_add_a = {1'b0, r_acc[2*XLEN-1:XLEN]};
         w_add_b = {1'b0, r_m};
      end
   end

   // Sign fix-up and word select for the final result.
   always_comb begin
      w_fix = r_acc[XLEN-1:0];
      case (r_f3)
         F3_MUL:                       w_fix = r_acc[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: w_fix = (r_sa ^ r_sb) ? w_sum[XLEN-1:0] : r_acc[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              w_fix = (r_sa ^ r_sb) ? w_sum[XLEN-1:0] : r_acc[XLEN-1:0];
         F3_REM, F3_REMU:              w_fix = r_sa ? w_sum[XLEN-1:0] : r_acc[2*XLEN-1:XLEN];
         default:                      w_fix = r_acc[XLEN-1:0];
      endcase
   end

   // Sequencer FSM with its datapath and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_f3     <= F3_MUL;
         r_cnt    <= {CW{1'b0}};
         r_a      <= {XLEN{1'b0}};
         r_b      <= {XLEN{1'b0}};
         r_m      <= {XLEN{1'b0}};
         r_acc    <= {(2*XLEN){1'b0}};
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= {XLEN{1'b0}};
      end else if ((r_state != S_IDLE) && bus.flush) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start && !bus.flush) begin
                  r_f3    <= m_funct3_e'(bus.funct3);
                  r_a     <= bus.op_a;
                  r_b     <= bus.op_b;
                  r_sa    <= op_signed_a(bus.funct3) & bus.op_a[XLEN-1];
                  r_sb    <= op_signed_b(bus.funct3) & bus.op_b[XLEN-1];
                  r_state <= S_PREP;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_PREP: begin
               r_cnt <= CW'(XLEN - 1);
               if (w_is_div && (r_b == {XLEN{1'b0}})) begin
                  r_result <= r_f3[1] ? r_a : {XLEN{1'b1}};
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else if (w_is_div) begin
                  r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                  r_m     <= w_mag_b;
                  r_state <= S_CALC;
               end else begin
                  r_acc   <= {{XLEN{1'b0}}, w_mag_b};
                  r_m     <= w_mag_a;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               if (w_is_div) begin
                  if (w_cout) begin
                     r_acc <= {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
                  end else begin
                     r_acc <= {r_acc[2*XLEN-2:0], 1'b0};
                  end
               end else if (r_acc[0]) begin
                  r_acc <= {w_sum, r_acc[XLEN-1:1]};
               end else begin
                  r_acc <= {1'b0, r_acc[2*XLEN-1:1]};
               end
               if (r_cnt == {CW{1'b0}}) begin
                  r_state <= S_FIX;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_FIX: begin
               r_result <= w_fix;
               r_done   <= 1'b1;
               r_state  <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // stall drops in DONE so the following stage captures the result on leaving it.
   assign bus.stall  = ((r_state == S_IDLE) & bus.start & ~bus.flush) |
                       (r_state == S_PREP) | (r_state == S_CALC) | (r_state == S_FIX);
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed vector table, randomized ops against an
// arithmetic reference model, and flush / mid-operation reset sequences.
module tb_mdu_sequencer;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   mdu_sequencer_if #(.XLEN(32)) bus ();

   mdu_sequencer #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // RV32M semantics computed with plain 64-bit arithmetic.
   function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sp;
      logic [63:0] up;
      logic        ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'b000: begin up = {32'h0, a} * {32'h0, b}; return up[31:0]; end
         3'b001: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
         3'b010: begin sp = longint'($signed(a)) * longint'({32'h0, b}); return sp[63:32]; end
         3'b011: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
         3'b100: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            else if (ovf) return 32'h8000_0000;
            else return $signed(a) / $signed(b);
         end
         3'b101: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            else return a / b;
         end
         3'b110: begin
            if (b == 32'h0) return a;
            else if (ovf) return 32'h0;
            else return $signed(a) % $signed(b);
         end
         default: begin
            if (b == 32'h0) return a;
            else return a % b;
         end
      endcase
   endfunction

   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit stall_ok, output bit pulse_ok);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      res  = 32'h0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = f3;
      bus.op_a   = a;
      bus.op_b   = b;
      #1 stall_ok = (bus.stall === 1'b1);
      while (!seen && lat < 100) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         lat++;
         if (bus.done === 1'b1) seen = 1'b1;
         else if (bus.stall !== 1'b1) stall_ok = 1'b0;
      end
      if (seen) begin
         res = bus.result;
         if (bus.stall !== 1'b0) stall_ok = 1'b0;
      end
      @(posedge clk);
      #1;
      pulse_ok = seen && (bus.done === 1'b0) && (bus.busy === 1'b0);
   endtask

   task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
      logic [31:0] res;
      int          lat;
      bit          s_ok;
      bit          p_ok;
      run_op(f3, a, b, res, lat, s_ok, p_ok);
      chk({name, "_result"}, res, exp);
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_stall"}, {31'h0, s_ok}, 32'h1);
      chk({name, "_pulse"}, {31'h0, p_ok}, 32'h1);
   endtask

   initial begin
      logic [31:0] last_exp;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rf;
      bit          done_seen;

      n_checks   = 0;
      n_errors   = 0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.flush  = 1'b0;
      bus.funct3 = 3'b000;
      bus.op_a   = 32'h0;
      bus.op_b   = 32'h0;

      #1;
      chk("reset_result", bus.result, 32'h0);
      chk("reset_done", {31'h0, bus.done}, 32'h0);
      chk("reset_busy", {31'h0, bus.busy}, 32'h0);
      chk("reset_stall", {31'h0, bus.stall}, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // flush beats start in IDLE
      @(negedge clk);
      bus.start = 1'b1;
      bus.flush = 1'b1;
      #1 chk("idle_flush_stall", {31'h0, bus.stall}, 32'h0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      chk("idle_flush_busy", {31'h0, bus.busy}, 32'h0);

      vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35};
      vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35};
      vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35};
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 35};
      vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 35};
      vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 35};
      vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        35};
      vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         35};
      vecs[8]  = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 2};
      vecs[9]  = '{3'b111, 32'd5,         32'd0,         32'd5,         2};
      vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35};
      vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 35};

      for (int i = 0; i < 12; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      end

      last_exp = 32'h0;
      for (int i = 0; i < 40; i++) begin
         rf = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       rb = 32'h0;
            1:       rb = $urandom_range(1, 15);
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         last_exp = ref_mdu(rf, ra, rb);
         do_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, last_exp,
               (rf[2] && rb == 32'h0) ? 2 : 35);
      end

      // flush in CALC cycle 10 of a MUL, with an ignored start earlier in CALC
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = 3'b000;
      bus.op_a   = 32'd5;
      bus.op_b   = 32'd6;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int e = 2; e <= 11; e++) begin
         @(posedge clk);
         #1;
         if (e == 5) begin
            bus.start  = 1'b1;
            bus.funct3 = 3'b100;
            bus.op_a   = 32'd9;
            bus.op_b   = 32'd3;
         end else begin
            bus.start = 1'b0;
         end
      end
      chk("flush_busy_before", {31'h0, bus.busy}, 32'h1);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      chk("flush_busy_after", {31'h0, bus.busy}, 32'h0);
      chk("flush_stall_after", {31'h0, bus.stall}, 32'h0);
      done_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) done_seen = 1'b1;
      end
      chk("flush_no_done", {31'h0, done_seen}, 32'h0);
      chk("flush_result_kept", bus.result, last_exp);

      // asynchronous reset in the middle of a DIV
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = 3'b100;
      bus.op_a   = 32'd1000;
      bus.op_b   = 32'd7;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_result", bus.result, 32'h0);
      chk("midrst_busy", {31'h0, bus.busy}, 32'h0);
      chk("midrst_done", {31'h0, bus.done}, 32'h0);
      chk("midrst_stall", {31'h0, bus.stall}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op("post_reset_mul", 3'b000, 32'd3, 32'd4, 32'd12, 35);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
